// File: rtl/time_of_day_counter.sv
// BCD hours:minutes:seconds counter advanced by a 1 Hz tick, with a RUNNING/STOPPED
// FSM and a range-checked parallel load.
module time_of_day_counter #(
   parameter int unsigned MAX_HOUR = 23
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Pulse,
   input  logic       Start,
   input  logic       Stop,
   input  logic       Load,
   input  logic [7:0] LoadH,
   input  logic [7:0] LoadM,
   input  logic [7:0] LoadS,
   output logic [7:0] Hours,
   output logic [7:0] Minutes,
   output logic [7:0] Seconds,
   output logic       Running,
   output logic       DayWrap,
   output logic       LoadErr
);

   localparam logic [7:0] MaxHourBcd = {4'(MAX_HOUR / 10), 4'(MAX_HOUR % 10)};

   typedef enum logic [0:0] {StStopped, StRunning} state_e;

   state_e     state_q, state_d;
   logic [7:0] hours_q, hours_d;
   logic [7:0] minutes_q, minutes_d;
   logic [7:0] seconds_q, seconds_d;
   logic       day_wrap_q, day_wrap_d;
   logic       load_err_q, load_err_d;
   logic       running;
   logic       load_ok;
   logic       tick;

   function automatic logic digits_ok(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   // Increment within 00..59.
   function automatic logic [7:0] inc_sixty(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h59) begin
         r = 8'h00;
      end else if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   // Plain two-digit BCD increment; the MAX_HOUR wrap is handled by the caller.
   function automatic logic [7:0] inc_bcd(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   // State register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= StStopped;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; Stop dominates Start.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StStopped: if (Start && !Stop) state_d = StRunning;
         StRunning: if (Stop)           state_d = StStopped;
         default:                       state_d = StStopped;
      endcase
   end

   // Output logic
   always_comb begin
      running = (state_q == StRunning);
   end

   assign load_ok = digits_ok(LoadH) && digits_ok(LoadM) && digits_ok(LoadS) &&
                    (LoadM <= 8'h59) && (LoadS <= 8'h59) && (LoadH <= MaxHourBcd);

   // A Load in the same cycle swallows the tick, valid or not.
   assign tick = running && Pulse && !Load;

   always_comb begin
      hours_d    = hours_q;
      minutes_d  = minutes_q;
      seconds_d  = seconds_q;
      day_wrap_d = 1'b0;
      load_err_d = 1'b0;
      if (Load) begin
         if (load_ok) begin
            hours_d   = LoadH;
            minutes_d = LoadM;
            seconds_d = LoadS;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (tick) begin
         seconds_d = inc_sixty(seconds_q);
         if (seconds_q == 8'h59) begin
            minutes_d = inc_sixty(minutes_q);
            if (minutes_q == 8'h59) begin
               if (hours_q == MaxHourBcd) begin
                  hours_d    = 8'h00;
                  day_wrap_d = 1'b1;
               end else begin
                  hours_d = inc_bcd(hours_q);
               end
            end
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         hours_q    <= 8'h00;
         minutes_q  <= 8'h00;
         seconds_q  <= 8'h00;
         day_wrap_q <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         hours_q    <= hours_d;
         minutes_q  <= minutes_d;
         seconds_q  <= seconds_d;
         day_wrap_q <= day_wrap_d;
         load_err_q <= load_err_d;
      end
   end

   assign Hours   = hours_q;
   assign Minutes = minutes_q;
   assign Seconds = seconds_q;
   assign Running = running;
   assign DayWrap = day_wrap_q;
   assign LoadErr = load_err_q;

   // Fields must stay legal BCD within range at all times.
   a_fields_legal: assert property (@(posedge Clk) disable iff (Reset)
      digits_ok(seconds_q) && digits_ok(minutes_q) && digits_ok(hours_q) &&
      (seconds_q <= 8'h59) && (minutes_q <= 8'h59) && (hours_q <= MaxHourBcd));

   a_wrap_is_midnight: assert property (@(posedge Clk) disable iff (Reset)
      day_wrap_q |-> (hours_q == 8'h00 && minutes_q == 8'h00 && seconds_q == 8'h00));

endmodule

// File: doc/time_of_day_counter.md
TIME_OF_DAY_COUNTER -- requirements
Module: time_of_day_counter

Interface
REQ-001 Parameter MAX_HOUR, default 23, is the highest hour value (decimal, legal 1..99) before the hours field wraps to 00.
REQ-002 Clk  input  1  system clock (50 MHz); all state changes occur on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high; forces the reset state immediately, independent of Clk.
REQ-004 Pulse  input  1  one-Clk-cycle-wide 1 Hz tick from the upstream pulse generator; each cycle it is sampled high is one second.
REQ-005 Start  input  1  synchronous request to enter RUNNING.
REQ-006 Stop  input  1  synchronous request to enter STOPPED.
REQ-007 Load  input  1  synchronous request to load LoadH/LoadM/LoadS.
REQ-008 LoadH  input  8  BCD hours to load (tens in [7:4], ones in [3:0]).
REQ-009 LoadM  input  8  BCD minutes to load.
REQ-010 LoadS  input  8  BCD seconds to load.
REQ-011 Hours  output  8  registered BCD hours.
REQ-012 Minutes  output  8  registered BCD minutes.
REQ-013 Seconds  output  8  registered BCD seconds.
REQ-014 Running  output  1  high while FSM is in RUNNING.
REQ-015 DayWrap  output  1  one-cycle pulse on the hours wrap to 00:00:00.
REQ-016 LoadErr  output  1  one-cycle pulse when a Load is rejected.

Function
REQ-017 FSM has two states, STOPPED and RUNNING; Running = (state == RUNNING).
REQ-018 STOPPED->RUNNING on Start=1 with Stop=0; RUNNING->STOPPED on Stop=1; Start and Stop high together -> STOPPED (Stop wins).
REQ-019 In RUNNING, Pulse=1 advances the time by exactly one second at that same Clk edge (one-cycle latency from Pulse to outputs); in STOPPED, Pulse is ignored and not remembered.
REQ-020 Seconds ones digit counts 0-9; at 9 it goes to 0 and carries into the tens digit, which counts 0-5; 59 -> 00 carries into Minutes.
REQ-021 Minutes follow the same 00-59 rule; 59 -> 00 carries into Hours.
REQ-022 Hours count 00..MAX_HOUR in BCD; an increment at MAX_HOUR with Minutes=59 and Seconds=59 yields 00:00:00 and asserts DayWrap for that single cycle.
REQ-023 Load is valid only if every digit <= 9, LoadM <= 59, LoadS <= 59 and LoadH <= MAX_HOUR.
REQ-024 A valid Load writes all three fields at the next edge in either state; the FSM state is unchanged.
REQ-025 An invalid Load leaves all fields unchanged and asserts LoadErr for one cycle.
REQ-026 Load=1 and Pulse=1 in the same cycle: Load takes priority and that tick is discarded, whether the Load is valid or invalid.
REQ-027 Start/Stop and Load in the same cycle are both honoured: the state transition and the load occur at the same edge.
REQ-028 Start while already RUNNING and Stop while already STOPPED have no effect.
REQ-029 DayWrap and LoadErr are low in every cycle not named above.
REQ-030 Fields never hold a non-BCD or out-of-range value.

Reset
REQ-031 While Reset=1: state=STOPPED, Hours=Minutes=Seconds=8'h00, Running=0, DayWrap=0, LoadErr=0; all inputs are ignored.
REQ-032 Reset asserted mid-count clears everything immediately; after release the block stays STOPPED until Start.
REQ-033 The first Clk edge after Reset deassertion samples inputs normally.

Verification
REQ-034 Reset, Start, 3 Pulses -> Running=1, 00:00:03; each Pulse changes Seconds at the edge it is sampled.
REQ-035 Load 00:00:59 via LoadH/M/S=8'h00/8'h00/8'h59, Start, 1 Pulse -> 00:01:00; Load 00:59:59, 1 Pulse -> 01:00:00.
REQ-036 Load 23:59:59, RUNNING, Pulse -> 00:00:00 with DayWrap=1 for one cycle; repeat with MAX_HOUR=12 and 12:59:59 -> same result.
REQ-037 Load LoadS=8'h60, then LoadM=8'h1A, then LoadH=8'h24 (MAX_HOUR=23) -> one LoadErr pulse each, time unchanged; Load together with Pulse -> loaded value, no increment.
REQ-038 STOPPED with Pulses applied -> time frozen; Start and Stop together -> STOPPED; Reset asserted between edges at 12:34:56 -> 00:00:00 and STOPPED immediately.
